// File: rtl/tc_pkg.sv
// Shared tensor-core types: element precision encoding and lane-count helpers.
package tc_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    PREC_FP32 = 2'd0,
    PREC_FP16 = 2'd1,
    PREC_INT8 = 2'd2,
    PREC_INT4 = 2'd3
  } prec_e;

  function automatic logic [3:0] lanes_of(input prec_e p);
    case (p)
      PREC_FP32: lanes_of = 4'd1;
      PREC_FP16: lanes_of = 4'd2;
      PREC_INT8: lanes_of = 4'd4;
      default:   lanes_of = 4'd8;
    endcase
  endfunction

  function automatic logic [5:0] lane_width_of(input prec_e p);
    case (p)
      PREC_FP32: lane_width_of = 6'd32;
      PREC_FP16: lane_width_of = 6'd16;
      PREC_INT8: lane_width_of = 6'd8;
      default:   lane_width_of = 6'd4;
    endcase
  endfunction

endpackage

// File: rtl/wb_packer.sv
// Packs right-aligned result elements into 32-bit words, lane 0 in the lowest bits.
// RESULT_WB_STRB_EN adds a byte-enable output covering the lanes filled so far.
module wb_packer
  import tc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  input  prec_e             prec,
  input  logic [WORD_W-1:0] elem,
  output logic [WORD_W-1:0] word,
  output logic              complete,
`ifdef RESULT_WB_STRB_EN
  output logic [3:0]        strb,
`endif
  output logic [3:0]        lanes_used
);

  logic [2:0]        lane_reg;
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] elem_masked;
  logic [4:0]        shamt;
  logic [3:0]        lanes;

  // word is the pack register with the current element already merged in,
  // so a completing handshake can hand it straight to the output register.
  always_comb begin
    lanes       = lanes_of(prec);
    elem_masked = elem;
    shamt       = 5'd0;
    case (prec)
      PREC_FP32: begin
        elem_masked = elem;
        shamt       = 5'd0;
      end
      PREC_FP16: begin
        elem_masked = {16'd0, elem[15:0]};
        shamt       = {lane_reg[0], 4'd0};
      end
      PREC_INT8: begin
        elem_masked = {24'd0, elem[7:0]};
        shamt       = {lane_reg[1:0], 3'd0};
      end
      default: begin
        elem_masked = {28'd0, elem[3:0]};
        shamt       = {lane_reg, 2'd0};
      end
    endcase
    word       = pack_reg | (elem_masked << shamt);
    lanes_used = {1'b0, lane_reg} + 4'd1;
    complete   = accept && (last || (lanes_used == lanes));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_reg <= 3'd0;
      pack_reg <= '0;
    end else if (clear) begin
      lane_reg <= 3'd0;
      pack_reg <= '0;
    end else if (accept) begin
      if (complete) begin
        lane_reg <= 3'd0;
        pack_reg <= '0;
      end else begin
        lane_reg <= lane_reg + 3'd1;
        pack_reg <= word;
      end
    end
  end

`ifdef RESULT_WB_STRB_EN
  logic [5:0] lane_w;
  logic [9:0] bits_used;

  assign lane_w    = lane_width_of(prec);
  assign bits_used = {6'd0, lanes_used} * {4'd0, lane_w};

  // A byte is enabled once any filled lane reaches into it (an INT4 nibble claims its byte).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strb
      assign strb[gi] = (bits_used > 10'(gi * 8));
    end
  endgenerate
`endif

endmodule

// File: rtl/result_wb_addrgen.sv
// Result write-back address generator: packs result elements into words and issues
// sequential buffer writes from a base address. RESULT_WB_STRB_EN adds wr_strb.
module result_wb_addrgen
  import tc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        prec,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_elems,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
`ifdef RESULT_WB_STRB_EN
  output logic [3:0]        wr_strb,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_reg;
  prec_e             prec_reg;
  logic [CNT_W-1:0]  remain_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              start_ok;
  logic              accept;
  logic              last_elem;
  logic              complete;
  logic [WORD_W-1:0] pack_word;
  logic [3:0]        lanes_used;
`ifdef RESULT_WB_STRB_EN
  logic [3:0]        pack_strb;
`endif

  assign start_ok  = (state_reg == ST_IDLE) && start;
  // New elements only flow when the output register is free or draining this cycle.
  assign in_ready  = (state_reg == ST_RUN) && (!wr_valid || wr_ready);
  assign accept    = in_valid && in_ready;
  assign last_elem = (remain_reg == CNT_W'(1));
  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);
  assign done      = (state_reg == ST_DONE);

  wb_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .accept     (accept),
    .last       (last_elem),
    .prec       (prec_reg),
    .elem       (in_data),
    .word       (pack_word),
    .complete   (complete),
`ifdef RESULT_WB_STRB_EN
    .strb       (pack_strb),
`endif
    .lanes_used (lanes_used)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      prec_reg   <= PREC_FP32;
      remain_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            prec_reg   <= prec_e'(prec);
            remain_reg <= num_elems;
            state_reg  <= (num_elems == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            remain_reg <= remain_reg - CNT_W'(1);
            if (last_elem) state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!wr_valid || wr_ready) state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Output register: a reload in the same cycle as a handshake keeps wr_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      addr_reg <= '0;
`ifdef RESULT_WB_STRB_EN
      wr_strb  <= 4'd0;
`endif
    end else begin
      if (start_ok) begin
        addr_reg <= base_addr;
      end else if (complete) begin
        addr_reg <= addr_reg + ADDR_W'(1);
      end
      if (complete) begin
        wr_valid <= 1'b1;
        wr_addr  <= addr_reg;
        wr_data  <= pack_word;
`ifdef RESULT_WB_STRB_EN
        wr_strb  <= pack_strb;
`endif
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_wb_addrgen.sv
// Scoreboard bench for result_wb_addrgen: jobs push expected writes, a monitor pops and compares.
module tb_result_wb_addrgen;
  import tc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  prec = 2'd0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] num_elems = 16'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
`ifdef RESULT_WB_STRB_EN
  logic [3:0]  wr_strb;
`endif

  result_wb_addrgen #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prec      (prec),
    .base_addr (base_addr),
    .num_elems (num_elems),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef RESULT_WB_STRB_EN
    .wr_strb   (wr_strb),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] job_data[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int lat_req = 0, lat_seen = 0;
  int to_req = 0, to_seen = 0;
  int stall_req = 0, stall_seen = 0;
  int stall_left = 0;
  bit rand_ready = 1'b0;

  function automatic int width_of(input logic [1:0] p);
    case (p)
      2'd0: return 32;
      2'd1: return 16;
      2'd2: return 8;
      default: return 4;
    endcase
  endfunction

  // Reference model: slice the element list into groups of 32/W, place element k at bit k*W.
  task automatic build_expect(input logic [1:0] p, input logic [15:0] b, input int n);
    int w_bits, lanes, words, cnt;
    logic [31:0] mask, word;
    wr_t e;
    w_bits = width_of(p);
    lanes  = 32 / w_bits;
    mask   = (w_bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << w_bits) - 32'h1);
    words  = (n + lanes - 1) / lanes;
    for (int w = 0; w < words; w++) begin
      word = 32'd0;
      cnt  = 0;
      for (int k = 0; k < lanes; k++) begin
        if (w * lanes + k < n) begin
          word = word | ((job_data[w * lanes + k] & mask) << (k * w_bits));
          cnt++;
        end
      end
      e.addr = 16'(int'(b) + w);
      e.data = word;
      e.strb = 4'((1 << ((cnt * w_bits + 7) / 8)) - 1);
      exp_q.push_back(e);
    end
  endtask

  // wr_ready driver: optional random back-pressure plus a directed 5-cycle stall on request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_req != stall_seen && wr_valid) begin
        stall_seen++;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: every comparison in the bench happens here.
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [15:0] prev_addr = 16'd0;
  logic [31:0] prev_data = 32'd0;
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      n_vec++;
      if (in_ready || wr_valid || busy || done || wr_addr != 16'd0 || wr_data != 32'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got in_ready=%b wr_valid=%b busy=%b done=%b addr=%h data=%h, need all zero",
                 in_ready, wr_valid, busy, done, wr_addr, wr_data);
      end
    end else begin
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr=%h data=%h, need no write", wr_addr, wr_data);
        end else if (wr_ready) begin
          e = exp_q.pop_front();
          n_vec++;
          if (wr_addr != e.addr || wr_data != e.data
`ifdef RESULT_WB_STRB_EN
              || wr_strb != e.strb
`endif
             ) begin
            n_err++;
            $display("FAIL write: got addr=%h data=%h, need addr=%h data=%h strb=%h",
                     wr_addr, wr_data, e.addr, e.data, e.strb);
          end else begin
            $display("write addr=%h data=%h ok", wr_addr, wr_data);
          end
        end
        if (!wr_ready) begin
          n_vec++;
          if (in_ready) begin
            n_err++;
            $display("FAIL in_ready_stall: got in_ready=1 during stall, need 0");
          end
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (!wr_valid || wr_addr != prev_addr || wr_data != prev_data) begin
          n_err++;
          $display("FAIL hold: got valid=%b addr=%h data=%h, need valid=1 addr=%h data=%h",
                   wr_valid, wr_addr, wr_data, prev_addr, prev_data);
        end
      end
      if (lat_req != lat_seen) begin
        lat_seen = lat_req;
        n_vec++;
        if (!wr_valid) begin
          n_err++;
          $display("FAIL latency: got wr_valid=0 one cycle after completing element, need 1");
        end
      end
      if (done) begin
        done_cnt++;
        n_vec++;
        if (prev_done || exp_q.size() != 0 || busy) begin
          n_err++;
          $display("FAIL done: got prev_done=%b pending_words=%0d busy=%b, need 0/0/0",
                   prev_done, exp_q.size(), busy);
        end
      end
    end
    if (to_req != to_seen) begin
      to_seen = to_req;
      n_vec++;
      n_err++;
      $display("FAIL timeout: got no DUT response within cycle budget, need progress");
    end
    prev_stall = rst && wr_valid && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    prev_done  = rst && done;
  end

  task automatic run_job(input logic [1:0] p, input logic [15:0] b, input int n,
                         input bit rnd, input int abort_after);
    int  lanes, d0;
    bit  hs;
    lanes = 32 / width_of(p);
    build_expect(p, b, n);
    d0 = done_cnt;
    start = 1'b1;
    prec = p;
    base_addr = b;
    num_elems = 16'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data = job_data[i];
      hs = 1'b0;
      for (int t = 0; t < 1000 && !hs; t++) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!hs) begin
        to_req++;
        return;
      end
      if (abort_after == i + 1) begin
        #2;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      if ((i % lanes) == lanes - 1 || i == n - 1) lat_req++;
      // A start while busy must be ignored.
      if (rnd && i == 0 && n >= 3) begin
        start = 1'b1;
        num_elems = 16'($urandom);
        base_addr = 16'($urandom);
        prec = 2'($urandom);
      end
    end
    start = 1'b0;
    for (int t = 0; t < 2000 && done_cnt == d0; t++) @(posedge clk);
    if (done_cnt == d0) to_req++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    job_data = '{32'hA, 32'hB, 32'hC};
    run_job(2'd0, 16'h0010, 3, 1'b0, 0);

    job_data = '{32'hDEAD_1111, 32'h0000_2222, 32'hFFFF_3333};
    run_job(2'd1, 16'h0200, 3, 1'b0, 0);

    job_data = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    run_job(2'd3, 16'h0300, 8, 1'b0, 0);

    job_data.delete();
    for (int i = 0; i < 8; i++) job_data.push_back(32'h100 + 32'(i * 17));
    stall_req++;
    run_job(2'd2, 16'h0400, 8, 1'b0, 0);

    job_data = '{32'h1234_5678, 32'h9ABC_DEF0};
    run_job(2'd0, 16'hFFFF, 2, 1'b0, 0);
    job_data.delete();
    run_job(2'd2, 16'h0500, 0, 1'b0, 0);

    job_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_job(2'd0, 16'h0040, 4, 1'b0, 2);
    run_job(2'd1, 16'h0050, 4, 1'b0, 0);

    rand_ready = 1'b1;
    for (int j = 0; j < 24; j++) begin
      int n;
      logic [15:0] b;
      n = $urandom_range(1, 21);
      b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      job_data.delete();
      for (int i = 0; i < n; i++) job_data.push_back($urandom);
      run_job(2'($urandom_range(0, 3)), b, n, 1'b1, 0);
    end

    rand_ready = 1'b0;
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
